// File: rtl/pipo_register_8bit.sv
// Parallel-in/parallel-out storage register with synchronous load enable
// and synchronous clear; q comes straight from the storage flops.
module pipo_register_8bit #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear has priority over load; otherwise the word is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_pipo_register_8bit.sv
// Directed plus randomized checks of pipo_register_8bit against a
// behavioural model of the clear/load/hold rules.
module tb_pipo_register_8bit;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  int unsigned      checks;
  int unsigned      errors;
  logic [WIDTH-1:0] model;

  pipo_register_8bit #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle, advance one rising edge, update the model, sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] dv,
                      input string tag);
    @(negedge clk);
    rst = r;
    en  = e;
    d   = dv;
    @(posedge clk);
    if (r)      model = 8'h00;
    else if (e) model = dv;
    #1;
    check(tag, q, model);
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    logic             rr;
    logic             re;
    checks = 0;
    errors = 0;
    model  = 'x;
    rst    = 1'b1;
    en     = 1'b0;
    d      = 8'h00;

    step(1'b1, 1'b0, 8'h00, "reset_edge1");
    step(1'b1, 1'b0, 8'h00, "reset_edge2");

    step(1'b0, 1'b1, 8'h11, "load_11");
    step(1'b0, 1'b1, 8'h22, "load_22");
    step(1'b0, 1'b1, 8'h33, "load_33");
    step(1'b0, 1'b1, 8'h44, "load_44");

    step(1'b0, 1'b0, 8'hAA, "hold_aa");
    for (int i = 0; i < 5; i++) begin
      rd = WIDTH'($urandom);
      step(1'b0, 1'b0, rd, "hold_rand");
    end
    check("hold_value_44", model, 8'h44);

    // Raise rst between edges: q must not move until the next rising edge.
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    d   = 8'h99;
    #2;
    check("sync_reset_between_edges", q, 8'h44);
    @(posedge clk);
    model = 8'h00;
    #1;
    check("sync_reset_after_edge", q, model);

    step(1'b1, 1'b1, 8'hFF, "reset_beats_load");
    step(1'b0, 1'b1, 8'h5A, "load_after_reset");

    step(1'b0, 1'b1, 8'h55, "bits_55");
    step(1'b0, 1'b1, 8'hAA, "bits_aa");
    step(1'b0, 1'b1, 8'hFF, "bits_ff");
    step(1'b0, 1'b1, 8'h00, "bits_00");

    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 9) == 0);
      re = 1'($urandom_range(0, 1));
      rd = WIDTH'($urandom);
      step(rr, re, rd, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
